// File: rtl/ldtu_ofifo_pkg.sv
// Shared SECDED helpers and output-word constants for the LDTU output FIFO.
// Latency: pure functions, no state.
// Backpressure: n/a.
package ldtu_ofifo_pkg;

   // Upper bound on supported payload width and matching codeword width.
   localparam int MAX_DW = 64;
   localparam int MAX_CW = 72;

   localparam logic [31:0] IDLE_WORD  = 32'hEAAAAAAA;
   localparam logic [31:0] FLUSH_WORD = 32'hFEEDC0DE;

   typedef struct packed {
      logic [MAX_DW-1:0] dat;
      logic              sec;
      logic              ded;
   } dec_t;

   // Smallest P with 2^P >= dw + P + 1 (descending scan keeps the smallest).
   function automatic int secded_p(input int dw);
      int p;
      p = 0;
      for (int i = 8; i >= 1; i--) begin
         if ((1 << i) >= dw + i + 1) p = i;
      end
      return p;
   endfunction

   // Extended Hamming: bit 0 is overall parity, check bits sit at powers of two,
   // data fills the remaining positions 1..dw+p in ascending order.
   function automatic logic [MAX_CW-1:0] secded_encode(input logic [MAX_DW-1:0] d,
                                                       input int dw, input int p);
      logic [MAX_CW-1:0] cw;
      logic              par;
      int                j;
      cw = '0;
      j  = 0;
      for (int pos = 1; pos < MAX_CW; pos++) begin
         if (pos <= dw + p && (pos & (pos - 1)) != 0) begin
            cw[pos] = d[j];
            j++;
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (i < p) begin
            par = 1'b0;
            for (int pos = 1; pos < MAX_CW; pos++) begin
               if (((pos >> i) & 1) != 0) par = par ^ cw[pos];
            end
            cw[1 << i] = par;
         end
      end
      cw[0] = ^cw;
      return cw;
   endfunction

   // Syndrome locates a single flip; overall parity separates single from double.
   function automatic dec_t secded_decode(input logic [MAX_CW-1:0] cw_in,
                                          input int dw, input int p);
      logic [MAX_CW-1:0] cw;
      logic              mis;
      int                syn;
      int                j;
      dec_t              r;
      cw  = cw_in;
      syn = 0;
      for (int pos = 1; pos < MAX_CW; pos++) begin
         if (pos <= dw + p && cw[pos]) syn = syn ^ pos;
      end
      mis = ^cw;
      r   = '0;
      if (mis) begin
         r.sec = 1'b1;
         if (syn != 0 && syn <= dw + p) cw[syn] = ~cw[syn];
      end else if (syn != 0) begin
         r.ded = 1'b1;
      end
      j = 0;
      for (int pos = 1; pos < MAX_CW; pos++) begin
         if (pos <= dw + p && (pos & (pos - 1)) != 0) begin
            r.dat[j] = cw[pos];
            j++;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ldtu_ofifo_mem.sv
// Codeword storage array with wrapping read/write pointers and occupancy level.
// Latency: write lands on the edge; head word is visible combinationally.
// Backpressure: none here; caller only asserts wr_en/rd_en when legal.
module ldtu_ofifo_mem
   import ldtu_ofifo_pkg::*;
#(
   parameter int CW    = 39,
   parameter int DEPTH = 16,
   parameter int LW    = 5
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_cw,
   input  logic          rd_en,
   output logic [CW-1:0] rd_cw,
   output logic [LW-1:0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [CW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage is deliberately left unreset; stale words are unreachable after clear.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= wr_cw;
   end

   // Pointers wrap naturally at DEPTH; level moves only on unbalanced traffic.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   assign rd_cw = mem[rd_ptr];

endmodule

// File: rtl/ldtu_ofifo_secded.sv
// LDTU output FIFO storing SECDED-protected words with flush/synch override.
// Latency: accepted read updates data_out and error pulses one edge later.
// Backpressure: writes into a full FIFO are dropped and flagged via sticky overflow.
module ldtu_ofifo_secded
   import ldtu_ofifo_pkg::*;
#(
   parameter int                DATA_W        = 32,
   parameter int                DEPTH         = 16,
   parameter int                AFULL_TH      = 12,
   parameter logic [DATA_W-1:0] IDLE_PATTERN  = IDLE_WORD,
   parameter logic [DATA_W-1:0] FLUSH_PATTERN = FLUSH_WORD
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic                       write_signal,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       read_signal,
   input  logic                       flush_b,
   input  logic                       synch,
   input  logic [DATA_W-1:0]          synch_pattern,
   input  logic [1:0]                 seu_inject,
   output logic [DATA_W-1:0]          data_out,
   output logic                       full_signal,
   output logic                       almost_full,
   output logic                       empty_signal,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       sec_error,
   output logic                       ded_error,
   output logic [7:0]                 err_count,
   output logic                       overflow
);

   localparam int P  = secded_p(DATA_W);
   localparam int CW = DATA_W + P + 1;
   localparam int LW = $clog2(DEPTH) + 1;

   logic          flush;
   logic          clr;
   logic          rd_acc;
   logic          wr_acc;
   logic [CW-1:0] enc_cw;
   logic [CW-1:0] rd_cw;
   dec_t          dec;

   assign flush = ~flush_b;
   assign clr   = flush | synch;

   // Flags come straight off the registered level so they move with the pointers.
   assign full_signal  = (level == LW'(DEPTH));
   assign almost_full  = (level >= LW'(AFULL_TH));
   assign empty_signal = (level == '0);

   // A read frees a slot in the same cycle, so write-at-full is fine alongside it.
   assign rd_acc = ~clr & read_signal & ~empty_signal;
   assign wr_acc = ~clr & write_signal & (~full_signal | rd_acc);

   // Fault injection flips the overall-parity bit and/or the first check bit.
   assign enc_cw = CW'(secded_encode(MAX_DW'(data_in), DATA_W, P)) ^ CW'(seu_inject);
   assign dec    = secded_decode(MAX_CW'(rd_cw), DATA_W, P);

   ldtu_ofifo_mem #(
      .CW    (CW),
      .DEPTH (DEPTH),
      .LW    (LW)
   ) u_mem (
      .CLK   (CLK),
      .reset (reset),
      .clr   (clr),
      .wr_en (wr_acc),
      .wr_cw (enc_cw),
      .rd_en (rd_acc),
      .rd_cw (rd_cw),
      .level (level)
   );

   // Output word, error pulses, error counter and sticky overflow.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         data_out  <= IDLE_PATTERN;
         sec_error <= 1'b0;
         ded_error <= 1'b0;
         err_count <= '0;
         overflow  <= 1'b0;
      end else begin
         sec_error <= 1'b0;
         ded_error <= 1'b0;
         if (flush) begin
            data_out <= FLUSH_PATTERN;
            overflow <= 1'b0;
         end else if (synch) begin
            data_out <= synch_pattern;
         end else begin
            if (rd_acc) begin
               data_out  <= dec.dat[DATA_W-1:0];
               sec_error <= dec.sec;
               ded_error <= dec.ded;
               if ((dec.sec | dec.ded) && err_count != 8'hFF)
                  err_count <= err_count + 8'd1;
            end else if (read_signal) begin
               data_out <= IDLE_PATTERN;
            end
            if (write_signal && !wr_acc) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ldtu_ofifo_secded.sv
module tb_ldtu_ofifo_secded;

   localparam logic [31:0] IDLE  = 32'hEAAAAAAA;
   localparam logic [31:0] FLUSH = 32'hFEEDC0DE;
   localparam int          DEP   = 16;
   localparam int          AFTH  = 12;

   logic        CLK;
   logic        reset;
   logic        write_signal;
   logic [31:0] data_in;
   logic        read_signal;
   logic        flush_b;
   logic        synch;
   logic [31:0] synch_pattern;
   logic [1:0]  seu_inject;
   logic [31:0] data_out;
   logic        full_signal;
   logic        almost_full;
   logic        empty_signal;
   logic [4:0]  level;
   logic        sec_error;
   logic        ded_error;
   logic [7:0]  err_count;
   logic        overflow;

   ldtu_ofifo_secded dut (
      .CLK           (CLK),
      .reset         (reset),
      .write_signal  (write_signal),
      .data_in       (data_in),
      .read_signal   (read_signal),
      .flush_b       (flush_b),
      .synch         (synch),
      .synch_pattern (synch_pattern),
      .seu_inject    (seu_inject),
      .data_out      (data_out),
      .full_signal   (full_signal),
      .almost_full   (almost_full),
      .empty_signal  (empty_signal),
      .level         (level),
      .sec_error     (sec_error),
      .ded_error     (ded_error),
      .err_count     (err_count),
      .overflow      (overflow)
   );

   always #5 CLK = ~CLK;

   // Reference model: a queue of (payload, injected-fault mask) entries.
   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  inj;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_dout;
   logic        m_sec;
   logic        m_ded;
   int          m_cnt;
   logic        m_ovf;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   task automatic check_all();
      chk("data_out", data_out, m_dout);
      chk("level", level, q.size());
      chk("empty", empty_signal, q.size() == 0);
      chk("full", full_signal, q.size() == DEP);
      chk("afull", almost_full, q.size() >= AFTH);
      chk("sec", sec_error, m_sec);
      chk("ded", ded_error, m_ded);
      chk("err_count", err_count, m_cnt);
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic model_reset();
      q.delete();
      m_dout = IDLE;
      m_sec  = 1'b0;
      m_ded  = 1'b0;
      m_cnt  = 0;
      m_ovf  = 1'b0;
   endtask

   // Drive one cycle, advance the model by the behavioural rules, check after the edge.
   task automatic cyc(input logic wr, input logic [31:0] din, input logic rd,
                      input logic fb, input logic sy, input logic [31:0] sp,
                      input logic [1:0] inj);
      ent_t e;
      int   sz;
      bit   rd_ok;
      write_signal  = wr;
      data_in       = din;
      read_signal   = rd;
      flush_b       = fb;
      synch         = sy;
      synch_pattern = sp;
      seu_inject    = inj;
      sz    = q.size();
      m_sec = 1'b0;
      m_ded = 1'b0;
      if (!fb) begin
         q.delete();
         m_dout = FLUSH;
         m_ovf  = 1'b0;
      end else if (sy) begin
         q.delete();
         m_dout = sp;
      end else begin
         rd_ok = rd && sz != 0;
         if (rd_ok) begin
            e      = q.pop_front();
            m_dout = e.d;
            m_sec  = (e.inj == 2'b01) || (e.inj == 2'b10);
            m_ded  = (e.inj == 2'b11);
            if ((m_sec || m_ded) && m_cnt < 255) m_cnt++;
         end else if (rd) begin
            m_dout = IDLE;
         end
         if (wr) begin
            if (sz < DEP || rd_ok) q.push_back({din, inj});
            else m_ovf = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
      check_all();
   endtask

   task automatic wr_word(input logic [31:0] d, input logic [1:0] inj);
      cyc(1'b1, d, 1'b0, 1'b1, 1'b0, 32'h0, inj);
   endtask

   task automatic rd_word();
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 2'b00);
   endtask

   task automatic rand_phase(input int ncyc, input int wr_pct, input int rd_pct);
      logic       wr, rd, fb, sy;
      logic [1:0] inj;
      for (int i = 0; i < ncyc; i++) begin
         wr  = $urandom_range(0, 99) < wr_pct;
         rd  = $urandom_range(0, 99) < rd_pct;
         fb  = ($urandom_range(0, 39) != 0);
         sy  = ($urandom_range(0, 49) == 0);
         inj = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cyc(wr, $urandom, rd, fb, sy, $urandom, inj);
      end
   endtask

   initial begin
      CLK           = 1'b0;
      reset         = 1'b0;
      write_signal  = 1'b0;
      data_in       = '0;
      read_signal   = 1'b0;
      flush_b       = 1'b1;
      synch         = 1'b0;
      synch_pattern = '0;
      seu_inject    = 2'b00;
      model_reset();

      #1 reset = 1'b1;
      #10;
      check_all();
      @(negedge CLK);
      reset = 1'b0;
      @(posedge CLK);
      #1;

      // Read while empty returns the idle word.
      rd_word();

      // Fill, overflow attempt, drain in order, then an empty read.
      for (int i = 0; i < 16; i++) wr_word(32'(i), 2'b00);
      wr_word(32'd99, 2'b00);
      for (int i = 0; i < 16; i++) rd_word();
      rd_word();

      // Flush clears overflow.
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);

      // Single-bit faults (overall parity, first check bit) and a double fault.
      wr_word(32'h12345678, 2'b01);
      rd_word();
      wr_word(32'hC0FFEE11, 2'b10);
      rd_word();
      wr_word(32'hA5A5A5A5, 2'b11);
      rd_word();
      idle_cyc();

      // Almost-full threshold, full, then balanced traffic at full.
      for (int i = 0; i < 12; i++) wr_word(32'h100 + 32'(i), 2'b00);
      for (int i = 12; i < 16; i++) wr_word(32'h100 + 32'(i), 2'b00);
      for (int i = 0; i < 3; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
      for (int i = 0; i < 16; i++) rd_word();

      // Read on empty with a same-cycle write: write is stored, no fall-through.
      cyc(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
      rd_word();

      // Flush mid-stream, then synch with a write that must be ignored.
      for (int i = 0; i < 5; i++) wr_word(32'h300 + 32'(i), 2'b00);
      rd_word();
      cyc(1'b1, 32'h777, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
      for (int i = 0; i < 3; i++) wr_word(32'h400 + 32'(i), 2'b00);
      cyc(1'b1, 32'h888, 1'b1, 1'b1, 1'b1, 32'h5A5A5A5A, 2'b00);
      idle_cyc();
      rd_word();

      // Asynchronous reset in the middle of a cycle discards stored words.
      for (int i = 0; i < 4; i++) wr_word(32'h500 + 32'(i), 2'b01);
      rd_word();
      @(negedge CLK);
      reset = 1'b1;
      model_reset();
      #2;
      check_all();
      @(negedge CLK);
      reset = 1'b0;
      @(posedge CLK);
      #1;
      rd_word();

      // Randomized traffic: balanced, write-heavy, read-heavy.
      rand_phase(800, 50, 50);
      rand_phase(600, 80, 30);
      rand_phase(600, 30, 80);

      // Error counter saturates at 255.
      idle_cyc();
      for (int i = 0; i < 260; i++) begin
         wr_word($urandom, 2'($urandom_range(1, 3)));
         rd_word();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
